// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and the IF->ID bus,
// applies ID redirects after one delay slot and survives stalls without losing state.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  input  logic [31:0]        inst_sram_rdata,
  output logic [31:0]        inst_o
);

  logic [31:0] r_pc;
  logic        r_ce;
  logic        r_br_pend;
  logic [31:0] r_br_pend_addr;
  logic        r_hold_vld;
  logic [31:0] r_hold_inst;
  logic        r_stall1_q;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_unused;

  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];

  // A redirect parked during a stall outranks a fresh one from ID.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (r_br_pend) begin
      w_next_pc = r_br_pend_addr;
    end else if (w_br_e) begin
      w_next_pc = w_br_addr;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
    end else if (!stall[0]) begin
      r_pc <= w_next_pc;
      r_ce <= 1'b1;
    end else begin
      r_pc <= r_pc;
      r_ce <= r_ce;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_pend      <= 1'b0;
      r_br_pend_addr <= 32'h0000_0000;
    end else if (!stall[0]) begin
      r_br_pend      <= 1'b0;
      r_br_pend_addr <= r_br_pend_addr;
    end else if (w_br_e && !r_br_pend) begin
      r_br_pend      <= 1'b1;
      r_br_pend_addr <= w_br_addr;
    end else begin
      r_br_pend      <= r_br_pend;
      r_br_pend_addr <= r_br_pend_addr;
    end
  end

  // Freeze the word returned on the first stalled edge; SRAM output may change afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_inst <= 32'h0000_0000;
    end else if (stall[1] && !r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_hold_inst <= inst_sram_rdata;
    end else if (!stall[1]) begin
      r_hold_vld  <= 1'b0;
      r_hold_inst <= r_hold_inst;
    end else begin
      r_hold_vld  <= r_hold_vld;
      r_hold_inst <= r_hold_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall1_q <= 1'b0;
    end else begin
      r_stall1_q <= stall[1];
    end
  end

  assign inst_sram_en    = r_ce & ~stall[0];
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign if_to_id_bus    = {r_ce, r_pc};
  assign inst_o          = r_hold_vld ? r_hold_inst : inst_sram_rdata;

  // Upper stall bits belong to later stages; bubbles are ID's business.
  assign w_unused = &{1'b0, stall[STALL_W-1:2], r_stall1_q};

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios then random stalls/redirects/resets,
// compared against a queue-based reference model and a behavioural SRAM.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] rdata;
  logic [31:0] inst_o;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_pend[$];
  logic [31:0] m_held[$];
  bit          force_dead = 1'b0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (rdata),
    .inst_o          (inst_o)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance model and SRAM.
  task automatic step(input bit r, input logic [5:0] st, input bit be, input logic [31:0] ba);
    logic        pre_en;
    logic [31:0] pre_addr;
    rst    = r;
    stall  = st;
    br_bus = {be, ba};
    @(negedge clk);
    pre_en   = m_ce & ~st[0];
    pre_addr = m_pc;
    chk("sram_en",   {32'd0, inst_sram_en}, {32'd0, pre_en});
    chk("sram_addr", {1'b0, inst_sram_addr}, {1'b0, m_pc});
    chk("id_bus",    if_to_id_bus, {m_ce, m_pc});
    chk("inst_o",    {1'b0, inst_o}, {1'b0, (m_held.size() != 0) ? m_held[0] : rdata});
    chk("tie_offs",  {29'd0, inst_sram_wen}, 33'd0);
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = RESET_PC;
      m_ce = 1'b0;
      m_pend.delete();
      m_held.delete();
    end else begin
      if (!st[0]) begin
        if (m_pend.size() != 0) m_pc = m_pend[0];
        else if (be)            m_pc = ba;
        else                    m_pc = m_pc + 32'd4;
        m_ce = 1'b1;
        m_pend.delete();
      end else if (be && m_pend.size() == 0) begin
        m_pend.push_back(ba);
      end
      if (st[1]) begin
        if (m_held.size() == 0) m_held.push_back(rdata);
      end else begin
        m_held.delete();
      end
    end
    if (force_dead)  rdata = 32'hDEAD_BEEF;
    else if (pre_en) rdata = memf(pre_addr);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 6'd0, 1'b0, 32'd0);
      chk("rst_bus", if_to_id_bus, {1'b0, RESET_PC});
    end
  endtask

  initial begin
    rst    = 1'b1;
    stall  = 6'd0;
    br_bus = 33'd0;
    rdata  = 32'd0;
    @(posedge clk);
    #1;
    m_pc = RESET_PC;
    m_ce = 1'b0;

    // Reset release and straight-line fetch with a taken beq at BFC00008
    do_reset(2);
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("seq0", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
    chk("ce_after_rst", {32'd0, if_to_id_bus[32]}, 33'd1);
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("seq1", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("seq2", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0008});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("slot", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_000C});
    step(1'b0, 6'd0, 1'b1, 32'hBFC0_0100); chk("tgt", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0100});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("tgt4", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});

    // jr captured during a 2-cycle stall; second redirect ignored
    step(1'b0, 6'd1, 1'b1, 32'h8000_1000); chk("jr_hold0", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});
    step(1'b0, 6'd1, 1'b1, 32'h8000_2000); chk("jr_hold1", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("jr_tgt", {1'b0, inst_sram_addr}, {1'b0, 32'h8000_1000});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("jr_tgt4", {1'b0, inst_sram_addr}, {1'b0, 32'h8000_1004});

    // PC wraps from FFFFFFFC to 0
    step(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC); chk("wrap_pre", {1'b0, inst_sram_addr}, {1'b0, 32'hFFFF_FFFC});
    step(1'b0, 6'd0, 1'b0, 32'd0); chk("wrap", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_0000});

    // Stall PC and IF/ID for 3 cycles at BFC00010 while SRAM output turns to DEADBEEF
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
    chk("stall_pc", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0010});
    force_dead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd3, 1'b0, 32'd0);
      chk("stall_addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0010});
      chk("stall_inst", {1'b0, inst_o}, {1'b0, memf(32'hBFC0_000C)});
    end
    force_dead = 1'b0;
    step(1'b0, 6'd0, 1'b0, 32'd0);
    chk("resume_addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0014});
    chk("resume_inst", {1'b0, inst_o}, {1'b0, memf(32'hBFC0_0010)});

    // Reset in the middle of a stall with a pending redirect and held instruction
    step(1'b0, 6'd3, 1'b1, 32'h1234_5678);
    step(1'b1, 6'd3, 1'b0, 32'd0);
    chk("midrst_bus", if_to_id_bus, {1'b0, RESET_PC});
    chk("midrst_inst", {1'b0, inst_o}, {1'b0, rdata});
    step(1'b0, 6'd0, 1'b0, 32'd0);
    chk("midrst_first", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});

    // Random stalls, redirects and occasional resets against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] st;
      st = 6'd0;
      if ($urandom_range(0, 3) == 0) st[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) st[1] = 1'b1;
      st[5:2] = 4'($urandom);
      step(($urandom_range(0, 49) == 0), st, ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
